// File: rtl/parity_step_cnt.sv
// Odd/even step counter: counts by 2 through the odd or even values of a
// WIDTH-bit range, up or down, with load, enable and wrap/saturate at range ends.
module parity_step_cnt #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sat_o
);

  typedef enum logic [1:0] {
    ODD_UP    = 2'd0,
    EVEN_UP   = 2'd1,
    ODD_DOWN  = 2'd2,
    EVEN_DOWN = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};

  mode_e            mode;
  logic             want_even;
  logic             down;
  logic             aligned;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] stepped;
  logic             at_end;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] sat_val;

  assign mode      = mode_e'(mode_i);
  assign want_even = mode_i[0];
  assign down      = mode_i[1];

  // Aligned when the count already has the parity the mode asks for.
  assign aligned = (cnt_o[0] != want_even);
  assign step    = aligned ? WIDTH'(2) : WIDTH'(1);
  assign stepped = down ? (cnt_o - step) : (cnt_o + step);

  // Range-end detection is explicit per mode, including realign steps that
  // would leave the range (EVEN_UP from MAX, ODD_DOWN from 0).
  always_comb begin
    at_end   = 1'b0;
    wrap_val = CNT_ZERO;
    sat_val  = CNT_ZERO;
    unique case (mode)
      ODD_UP: begin
        at_end   = (cnt_o == CNT_MAX);
        wrap_val = CNT_ONE;
        sat_val  = CNT_MAX;
      end
      EVEN_UP: begin
        at_end   = (cnt_o == CNT_MAX_M1) || (cnt_o == CNT_MAX);
        wrap_val = CNT_ZERO;
        sat_val  = CNT_MAX_M1;
      end
      ODD_DOWN: begin
        at_end   = (cnt_o == CNT_ONE) || (cnt_o == CNT_ZERO);
        wrap_val = CNT_MAX;
        sat_val  = CNT_ONE;
      end
      EVEN_DOWN: begin
        at_end   = (cnt_o == CNT_ZERO);
        wrap_val = CNT_MAX_M1;
        sat_val  = CNT_ZERO;
      end
      default: begin
        at_end   = 1'b0;
        wrap_val = CNT_ZERO;
        sat_val  = CNT_ZERO;
      end
    endcase
  end

  // Count register: reset > load > enabled step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_o  <= CNT_ONE;
      wrap_o <= 1'b0;
      sat_o  <= 1'b0;
    end else if (load_i) begin
      cnt_o  <= load_val_i;
      wrap_o <= 1'b0;
      sat_o  <= 1'b0;
    end else if (en_i) begin
      if (!at_end) begin
        cnt_o  <= stepped;
        wrap_o <= 1'b0;
        sat_o  <= 1'b0;
      end else if (SATURATE) begin
        cnt_o  <= sat_val;
        wrap_o <= 1'b0;
        sat_o  <= 1'b1;
      end else begin
        cnt_o  <= wrap_val;
        wrap_o <= 1'b1;
        sat_o  <= 1'b0;
      end
    end else begin
      wrap_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_step_cnt.sv
// Directed and randomized checks of parity_step_cnt in three configurations:
// 8-bit wrapping, 8-bit saturating, 4-bit wrapping.
module tb_parity_step_cnt;

  logic clk;
  int   n_pass;
  int   n_total;

  // 8-bit wrapping instance
  logic       r8, e8, l8;
  logic [1:0] m8;
  logic [7:0] v8, c8;
  logic       w8, s8;
  // 8-bit saturating instance
  logic       rs, es, ls;
  logic [1:0] ms;
  logic [7:0] vs, cs;
  logic       ws, ss;
  // 4-bit wrapping instance
  logic       rf, ef, lf;
  logic [1:0] mf;
  logic [3:0] vf, cf;
  logic       wf, sf;

  parity_step_cnt #(.WIDTH(8), .SATURATE(1'b0)) u8 (
    .clk(clk), .reset(r8), .en_i(e8), .mode_i(m8), .load_i(l8),
    .load_val_i(v8), .cnt_o(c8), .wrap_o(w8), .sat_o(s8));

  parity_step_cnt #(.WIDTH(8), .SATURATE(1'b1)) us (
    .clk(clk), .reset(rs), .en_i(es), .mode_i(ms), .load_i(ls),
    .load_val_i(vs), .cnt_o(cs), .wrap_o(ws), .sat_o(ss));

  parity_step_cnt #(.WIDTH(4), .SATURATE(1'b0)) u4 (
    .clk(clk), .reset(rf), .en_i(ef), .mode_i(mf), .load_i(lf),
    .load_val_i(vf), .cnt_o(cf), .wrap_o(wf), .sat_o(sf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference behaviour written in plain integer arithmetic against the ranges.
  function automatic void ref_step(input int w, input bit sat, input bit rst,
                                   input bit ld, input bit en, input int mode,
                                   input int val, inout int cnt, inout bit wrp,
                                   inout bit st);
    int mx, lo, hi, stp, nxt;
    bit even, dn;
    mx = (1 << w) - 1;
    if (rst) begin
      cnt = 1; wrp = 0; st = 0;
    end else if (ld) begin
      cnt = val; wrp = 0; st = 0;
    end else if (en) begin
      even = (mode % 2) == 1;
      dn   = (mode / 2) == 1;
      lo   = even ? 0 : 1;
      hi   = even ? mx - 1 : mx;
      stp  = ((cnt % 2) == (even ? 0 : 1)) ? 2 : 1;
      nxt  = dn ? cnt - stp : cnt + stp;
      if (nxt > hi || nxt < lo) begin
        if (sat) begin
          cnt = dn ? lo : hi; wrp = 0; st = 1;
        end else begin
          cnt = dn ? hi : lo; wrp = 1; st = 0;
        end
      end else begin
        cnt = nxt; wrp = 0; st = 0;
      end
    end else begin
      wrp = 0;
    end
  endfunction

  int t2_exp [7];
  int mc4, mcs;
  bit mw4, ms4, mws, mss;

  initial begin
    n_pass = 0; n_total = 0;
    r8 = 1; e8 = 0; l8 = 0; m8 = 0; v8 = 0;
    rs = 1; es = 0; ls = 0; ms = 0; vs = 0;
    rf = 1; ef = 0; lf = 0; mf = 0; vf = 0;

    // Reset state
    step();
    chk("rst8_cnt", c8, 1); chk("rst8_wrap", w8, 0); chk("rst8_sat", s8, 0);
    chk("rsts_cnt", cs, 1); chk("rsts_sat", ss, 0);
    chk("rst4_cnt", cf, 1); chk("rst4_wrap", wf, 0);
    r8 = 0; rs = 0; rf = 0;

    // Odd up through a full range and past the wrap
    m8 = 2'd0; e8 = 1;
    for (int i = 1; i <= 130; i++) begin
      step();
      chk("t1_cnt", c8, ((2 * i) % 256) + 1);
      chk("t1_wrap", w8, (i == 128) ? 1 : 0);
    end

    // Load 4, even up then even down through the bottom wrap
    e8 = 0; l8 = 1; v8 = 8'd4;
    step();
    chk("t2_load", c8, 4);
    l8 = 0; e8 = 1;
    t2_exp = '{6, 8, 6, 4, 2, 0, 254};
    for (int i = 0; i < 7; i++) begin
      m8 = (i < 2) ? 2'd1 : 2'd3;
      step();
      chk("t2_cnt", c8, t2_exp[i]);
      chk("t2_wrap", w8, (i == 6) ? 1 : 0);
    end

    // Realign: 6 in odd-up goes to 7 then 9; 255 in even-up wraps to 0
    e8 = 0; l8 = 1; v8 = 8'd6;
    step();
    l8 = 0; e8 = 1; m8 = 2'd0;
    step(); chk("t3_realign", c8, 7); chk("t3_realign_wrap", w8, 0);
    step(); chk("t3_after", c8, 9);
    e8 = 0; l8 = 1; v8 = 8'd255;
    step();
    l8 = 0; e8 = 1; m8 = 2'd1;
    step(); chk("t3_max_even", c8, 0); chk("t3_max_even_wrap", w8, 1);
    chk("t3_nosat", s8, 0);

    // Load wins over enable; reset wins over load; idle holds
    e8 = 1; l8 = 1; v8 = 8'd100; m8 = 2'd0;
    step(); chk("t5_load_en", c8, 100); chk("t5_load_wrap", w8, 0);
    r8 = 1; l8 = 1; v8 = 8'd50; e8 = 1;
    step(); chk("t5_rst_load", c8, 1);
    r8 = 0; l8 = 0; e8 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_idle_cnt", c8, 1);
      chk("t5_idle_wrap", w8, 0);
    end

    // Wrap pulse clears when enable drops
    l8 = 1; v8 = 8'd255;
    step();
    l8 = 0; e8 = 1; m8 = 2'd0;
    step(); chk("t5_wrap_pulse", w8, 1); chk("t5_wrap_cnt", c8, 1);
    e8 = 0;
    step(); chk("t5_wrap_clear", w8, 0); chk("t5_hold_cnt", c8, 1);

    // Saturating: hold at 255, then step down clears sat
    ls = 1; vs = 8'd253;
    step();
    ls = 0; es = 1; ms = 2'd0;
    step(); chk("t4_255", cs, 255); chk("t4_sat0", ss, 0);
    step(); chk("t4_hold1", cs, 255); chk("t4_sat1", ss, 1); chk("t4_nowrap", ws, 0);
    step(); chk("t4_hold2", cs, 255); chk("t4_sat2", ss, 1);
    ms = 2'd2;
    step(); chk("t4_down", cs, 253); chk("t4_satclr", ss, 0);
    // Even up from 255 saturates at 254; odd down from 0 saturates at 1
    es = 0; ls = 1; vs = 8'd255;
    step();
    ls = 0; es = 1; ms = 2'd1;
    step(); chk("t4_eu_max", cs, 254); chk("t4_eu_sat", ss, 1);
    es = 0; ls = 1; vs = 8'd0;
    step(); chk("t4_load_clr", ss, 0);
    ls = 0; es = 1; ms = 2'd2;
    step(); chk("t4_od_zero", cs, 1); chk("t4_od_sat", ss, 1);
    es = 0;
    step(); chk("t4_sat_hold", ss, 1); chk("t4_cnt_hold", cs, 1);
    ls = 1; vs = 8'd10;
    step(); chk("t4_load10", cs, 10); chk("t4_load_satclr", ss, 0);
    ls = 0;

    // 4-bit: odd down from 1 wraps to 15
    mf = 2'd2; ef = 1;
    step(); chk("t6_wrap15", cf, 15); chk("t6_wrap", wf, 1);
    step(); chk("t6_13", cf, 13); chk("t6_nowrap", wf, 0);

    // Randomized: 4-bit wrapping and 8-bit saturating against the model
    rf = 1; rs = 1; lf = 0; ls = 0; ef = 0; es = 0;
    step();
    mc4 = 1; mw4 = 0; ms4 = 0;
    mcs = 1; mws = 0; mss = 0;
    chk("r_rst4", cf, mc4); chk("r_rsts", cs, mcs);
    for (int i = 0; i < 10000; i++) begin
      rf = ($urandom_range(63) == 0);
      lf = ($urandom_range(7) == 0);
      ef = ($urandom_range(3) != 0);
      mf = 2'($urandom_range(3));
      vf = 4'($urandom_range(15));
      rs = ($urandom_range(63) == 0);
      ls = ($urandom_range(15) == 0);
      es = ($urandom_range(3) != 0);
      ms = 2'($urandom_range(3));
      vs = 8'($urandom_range(255));
      step();
      ref_step(4, 1'b0, rf, lf, ef, int'(mf), int'(vf), mc4, mw4, ms4);
      ref_step(8, 1'b1, rs, ls, es, int'(ms), int'(vs), mcs, mws, mss);
      chk("r4_cnt", cf, mc4); chk("r4_wrap", wf, mw4); chk("r4_sat", sf, ms4);
      chk("rs_cnt", cs, mcs); chk("rs_wrap", ws, mws); chk("rs_sat", ss, mss);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
